apb_sram_ctrl: RTL and testbench

- Parametrised APB slave fronting an on-chip word-addressed SRAM: configurable data width, depth, base address and access wait states.
- Adds address decode and range checking, byte-strobe writes, wait-state insertion, and protocol-abort handling.
- Sits on the core's APB peripheral bus as the next-generation data/boot RAM slave.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_sram_ctrl_if.sv | 32 +++
 rtl/apb_sram_mem.sv | 56 +++++
 rtl/apb_sram_ctrl.sv | 115 +++++++++++
 tb/tb_apb_sram_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared FSM encoding, counter width and response codes for the APB SRAM slave.
// Parity support is selected with APB_SRAM_PARITY_EN (see apb_sram_mem).
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int CNT_W = 4;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  function automatic int apb_strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_sram_ctrl_if.sv
// APB bus bundle between the peripheral-bus master and the SRAM slave.
// The same bundle is used whether or not APB_SRAM_PARITY_EN is defined.
interface apb_sram_ctrl_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int STRB_WIDTH = apb_strb_w(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [STRB_WIDTH-1:0] pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );

endinterface

// File: rtl/apb_sram_mem.sv
// Single-port word RAM with byte enables and registered read.
// APB_SRAM_PARITY_EN adds one even-parity bit per byte lane.
module apb_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  ren,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  par_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (ren) rdata <= mem[idx];
  end

`ifdef APB_SRAM_PARITY_EN
  logic [STRB_WIDTH-1:0] par [DEPTH];
  logic [STRB_WIDTH-1:0] rpar;
  logic [STRB_WIDTH-1:0] calc;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (be[i]) par[idx][i] <= ^wdata[i*8 +: 8];
      end
    end
    if (ren) rpar <= par[idx];
  end

  always_comb begin
    calc = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      calc[i] = ^rdata[i*8 +: 8];
    end
  end

  assign par_err = |(calc ^ rpar);
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/apb_sram_ctrl.sv
// APB slave front-end for the data/boot SRAM: decode, wait states, aborts.
// Optional per-lane parity checking is enabled with APB_SRAM_PARITY_EN.
module apb_sram_ctrl
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    WAIT_STATES = 0
) (
  input logic             pclk,
  input logic             rst,
  apb_sram_ctrl_if.slave  bus
);

  localparam int SW  = apb_strb_w(DATA_WIDTH);
  localparam int IW  = $clog2(DEPTH);
  localparam int LSB = $clog2(SW);

  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(DEPTH * SW);
  localparam logic [ADDR_WIDTH:0] AMASK = (ADDR_WIDTH+1)'(SW - 1);
  localparam logic [CNT_W-1:0]    WS    = CNT_W'(WAIT_STATES);

  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_ACCESS = ACCESS;

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic [IW-1:0]         idx;
  logic [SW-1:0]         stb_q;
  logic                  err_q;
  logic                  wr_q;
  logic                  rd_zero;
  logic [ADDR_WIDTH:0]   off;
  logic                  dec_err;
  logic                  setup;
  logic                  active;
  logic                  ren;
  logic                  we;
  logic                  par_err;
  logic [DATA_WIDTH-1:0] rdata;

  // Extra top bit makes addresses below the base wrap to a huge offset.
  assign off     = {1'b0, bus.paddr} - {1'b0, BASE_ADDR};
  assign dec_err = (off >= SPAN) | (|(off & AMASK));
  assign idx_d   = off[LSB +: IW];

  assign setup  = bus.psel & ~bus.penable;
  assign active = bus.psel & bus.penable;

  assign bus.pready = (state == S_ACCESS) && (cnt == WS);
  assign bus.perr   = (bus.pready && (err_q || (!wr_q && par_err)))
                    ? RESP_SLVERR : RESP_OKAY;

  assign ren = (state == S_IDLE) & setup & ~bus.pwrite;
  assign we  = bus.pready & active & wr_q & ~err_q;
  assign idx = (state == S_IDLE) ? idx_d : idx_q;

  // Error reads mask the RAM output so the bus sees zero.
  assign bus.prdata = rd_zero ? '0 : rdata;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      stb_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (setup) begin
            state <= S_ACCESS;
            cnt   <= '0;
            idx_q <= idx_d;
            err_q <= dec_err;
            wr_q  <= bus.pwrite;
            stb_q <= bus.pstb;
            if (!bus.pwrite) rd_zero <= dec_err;
          end
        end
        (state == S_ACCESS): begin
          if (bus.pready || !active) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  apb_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .STRB_WIDTH (SW),
    .IDX_W      (IW)
  ) u_mem (
    .clk     (pclk),
    .ren     (ren),
    .we      (we),
    .idx     (idx),
    .be      (stb_q),
    .wdata   (bus.pdata),
    .rdata   (rdata),
    .par_err (par_err)
  );

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Bench for apb_sram_ctrl: directed table, corner sequences and a random run.
// Two DUTs share the stimulus: WAIT_STATES=0 (sel=0) and WAIT_STATES=3 (sel=1).
module tb_apb_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  stb;
  logic        sel;

  apb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  apb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  assign b0.paddr   = addr;
  assign b0.pdata   = wdata;
  assign b0.psel    = psel & ~sel;
  assign b0.penable = penable;
  assign b0.pwrite  = pwrite;
  assign b0.pstb    = stb;
  assign b3.paddr   = addr;
  assign b3.pdata   = wdata;
  assign b3.psel    = psel & sel;
  assign b3.penable = penable;
  assign b3.pwrite  = pwrite;
  assign b3.pstb    = stb;

  apb_sram_ctrl #(.WAIT_STATES(0)) dut0 (.pclk(clk), .rst(rst), .bus(b0));
  apb_sram_ctrl #(.WAIT_STATES(3)) dut3 (.pclk(clk), .rst(rst), .bus(b3));

  logic        rdy;
  logic        rerr;
  logic [31:0] rdat;
  assign rdy  = sel ? b3.pready : b0.pready;
  assign rerr = sel ? b3.perr   : b0.perr;
  assign rdat = sel ? b3.prdata : b0.prdata;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1; the next transfer follows back-to-back.
  task automatic xfer(input logic s, input logic [31:0] a,
                      input logic [31:0] d, input logic w,
                      input logic [3:0] st, input int abort_at,
                      output logic [31:0] rd, output logic er,
                      output int n);
    bit aborted;
    bit seen;
    sel = s; addr = a; wdata = d; pwrite = w; stb = st;
    psel = 1'b1; penable = 1'b0;
    rd = '0; er = 1'b0; n = 0; aborted = 0; seen = 0;
    @(posedge clk); #1 penable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy) begin
        n = k; rd = rdat; er = rerr;
        break;
      end
      if (k == abort_at) begin
        psel = 1'b0; penable = 1'b0; aborted = 1;
        break;
      end
    end
    if (aborted) begin
      repeat (6) begin
        @(negedge clk);
        if (rdy) seen = 1;
      end
      chk("abort_no_pready", 32'(seen), 32'd0);
    end
    @(posedge clk); #1;
    if (n > 0) chk("pready_one_cycle", 32'(rdy), 32'd0);
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct packed {
    logic        s;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  logic [31:0] m [2][16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    bit          seen;

    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    bit          seen;
    logic        s;
    logic        w;
    logic        bad;
    logic [3:0]  st;
    logic [31:0] a;
    logic [31:0] d;
    int          wi;
    int          kind;

    tbl[0]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0, 1'b0, 4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h8000_0000, 32'h1122_3344, 1'b1, 4'hF, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 32'h8000_0000, 32'hAABB_CCDD, 1'b1, 4'h5, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h8000_0000, 32'h0, 1'b0, 4'hA, 32'h11BB_33DD, 1'b0};
    tbl[5]  = '{1'b0, 32'h8000_1000, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1};
    tbl[6]  = '{1'b0, 32'h8000_0002, 32'h1234_5678, 1'b1, 4'hF, 32'h0, 1'b1};
    tbl[7]  = '{1'b0, 32'h8000_0000, 32'h0, 1'b0, 4'h0, 32'h11BB_33DD, 1'b0};
    tbl[8]  = '{1'b0, 32'h8000_0010, 32'hCAFE_F00D, 1'b1, 4'h0, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 32'h8000_0010, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{1'b0, 32'h7FFF_FFFC, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 32'h8000_0FFC, 32'h0BAD_C0DE, 1'b1, 4'hF, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 32'h8000_0FFC, 32'h0, 1'b0, 4'h0, 32'h0BAD_C0DE, 1'b0};
    tbl[13] = '{1'b1, 32'h8000_0020, 32'h0102_0304, 1'b1, 4'hF, 32'h0, 1'b0};
    tbl[14] = '{1'b1, 32'h8000_0020, 32'h0, 1'b0, 4'h0, 32'h0102_0304, 1'b0};
    tbl[15] = '{1'b1, 32'h8000_0020, 32'h0, 1'b0, 4'h0, 32'h0102_0304, 1'b0};
    tbl[16] = '{1'b1, 32'h8000_1004, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1};

    rst = 1'b1; sel = 1'b0; addr = '0; wdata = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; stb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready0", 32'(b0.pready), 32'd0);
    chk("rst_perr0",   32'(b0.perr),   32'd0);
    chk("rst_prdata0", b0.prdata,      32'd0);
    chk("rst_pready3", 32'(b3.pready), 32'd0);
    chk("rst_perr3",   32'(b3.perr),   32'd0);
    chk("rst_prdata3", b3.prdata,      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      xfer(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].st, 0, rd, er, n);
      chk($sformatf("tbl%0d_perr", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_cycles", i), n, tbl[i].s ? 32'd4 : 32'd1);
      if (!tbl[i].w) chk($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
    end

    // penable without a setup phase must be ignored.
    sel = 1'b0; addr = 32'h8000_0000; wdata = 32'hFFFF_FFFF;
    pwrite = 1'b1; stb = 4'hF; psel = 1'b1; penable = 1'b1; seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy) seen = 1;
    end
    psel = 1'b0; penable = 1'b0;
    chk("noset_no_pready", 32'(seen), 32'd0);
    @(posedge clk); #1;
    xfer(1'b0, 32'h8000_0000, 32'h0, 1'b0, 4'h0, 0, rd, er, n);
    chk("noset_mem_kept", rd, 32'h11BB_33DD);

    // Abort a wait-stated write after one access cycle.
    xfer(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 1'b1, 4'hF, 1, rd, er, n);
    xfer(1'b1, 32'h8000_0020, 32'h0, 1'b0, 4'h0, 0, rd, er, n);
    chk("abort_mem_kept", rd, 32'h0102_0304);

    // Reset in the middle of a write access.
    sel = 1'b1; addr = 32'h8000_0020; wdata = 32'h5555_5555;
    pwrite = 1'b1; stb = 4'hF; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pready", 32'(b3.pready), 32'd0);
    chk("midrst_perr",   32'(b3.perr),   32'd0);
    chk("midrst_prdata", b3.prdata,      32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b1, 32'h8000_0020, 32'h0, 1'b0, 4'h0, 0, rd, er, n);
    chk("midrst_mem_kept", rd, 32'h0102_0304);

`ifdef APB_SRAM_PARITY_EN
    dut0.u_mem.mem[4][0] = ~dut0.u_mem.mem[4][0];
    xfer(1'b0, 32'h8000_0010, 32'h0, 1'b0, 4'h0, 0, rd, er, n);
    chk("parity_perr", 32'(er), 32'd1);
    chk("parity_raw", rd, 32'hDEAD_BEEE);
`endif

    // Random traffic against a word-array model of both RAM windows.
    for (int s2 = 0; s2 < 2; s2++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        m[s2][i] = d;
        xfer(s2[0], 32'h8000_0100 + 32'(i * 4), d, 1'b1, 4'hF, 0, rd, er, n);
      end
    end
    for (int t = 0; t < 200; t++) begin
      s    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      wi   = $urandom_range(0, 15);
      a    = 32'h8000_0100 + 32'(wi * 4);
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      if (kind == 9) a = ($urandom_range(0, 1) == 1)
                         ? 32'h8000_1000 + 32'($urandom_range(0, 255) * 4)
                         : 32'h7FFF_FF00 + 32'($urandom_range(0, 63) * 4);
      bad = (kind >= 8);
      w   = 1'($urandom_range(0, 1));
      st  = 4'($urandom);
      d   = $urandom;
      xfer(s, a, d, w, st, 0, rd, er, n);
      chk("rnd_perr", 32'(er), 32'(bad));
      chk("rnd_cycles", n, s ? 32'd4 : 32'd1);
      if (!w) begin
        chk("rnd_prdata", rd, bad ? 32'd0 : m[s][wi]);
      end else if (!bad) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) m[s][wi][b*8 +: 8] = d[b*8 +: 8];
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
